mode_counter: RTL

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/counter_pkg.sv | 5 +
 rtl/mode_counter_if.sv | 18 +
 rtl/mode_counter.sv | 66 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared enums for mode_counter
package counter_pkg;
   typedef enum logic [1:0] {WRAP, SATURATE, ONESHOT, HOLD} mode_e;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/mode_counter_if.sv
// mode_counter_if: control and status bundle for mode_counter
interface mode_counter_if import counter_pkg::*; #(parameter int WIDTH = 8);
   logic enable;
   logic load;
   logic [WIDTH-1:0] load_value;
   logic dir;
   mode_e mode;
   logic [WIDTH-1:0] limit;
   logic clear_ovf;
   logic [WIDTH-1:0] count;
   logic tc;
   logic done;
   logic overflow;
   modport master (output enable, load, load_value, dir, mode, limit, clear_ovf,
                   input count, tc, done, overflow);
   modport slave (input enable, load, load_value, dir, mode, limit, clear_ovf,
                  output count, tc, done, overflow);
endinterface

// File: rtl/mode_counter.sv
// mode_counter: up/down counter with WRAP/SATURATE/ONESHOT/HOLD modes,
// registered terminal-count pulse and sticky overflow
module mode_counter import counter_pkg::*; #(parameter int WIDTH = 8) (
   input logic clock,
   input logic reset,
   mode_counter_if.slave bus
);
   state_e state, state_nx;
   logic [WIDTH-1:0] count_nx;
   logic tc_nx, ovf_nx, sat, sat_nx, term, step;
   assign term = bus.dir ? bus.count >= bus.limit : bus.count == '0;
   assign step = bus.enable && state != DONE && bus.mode != HOLD;
   assign bus.done = state == DONE;
   always_comb begin
      state_nx = state;
      count_nx = bus.count;
      tc_nx = 1'b0;
      ovf_nx = bus.overflow & ~bus.clear_ovf;
      sat_nx = sat;
      if (bus.load) begin
         count_nx = bus.load_value;
         state_nx = RUN;
         sat_nx = 1'b0;
      end else if (step) begin
         state_nx = RUN;
         if (!term) begin
            count_nx = bus.dir ? bus.count + WIDTH'(1) : bus.count - WIDTH'(1);
            sat_nx = 1'b0;
         end else begin
            case (bus.mode)
               WRAP: begin
                  count_nx = bus.dir ? '0 : bus.limit;
                  tc_nx = 1'b1;
                  ovf_nx = 1'b1;
               end
               // sat remembers we already pulsed at this terminal value
               SATURATE: begin
                  count_nx = bus.dir ? bus.limit : '0;
                  tc_nx = ~sat;
                  sat_nx = 1'b1;
               end
               ONESHOT: begin
                  state_nx = DONE;
                  tc_nx = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         bus.count <= '0;
         bus.tc <= 1'b0;
         bus.overflow <= 1'b0;
         sat <= 1'b0;
      end else begin
         state <= state_nx;
         bus.count <= count_nx;
         bus.tc <= tc_nx;
         bus.overflow <= ovf_nx;
         sat <= sat_nx;
      end
   end
endmodule
